// File: rtl/slc3_mem_pkg.sv
// rtl/slc3_mem_pkg.sv - shared types and constants for the SLC-3 memory bridge
package slc3_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD,
      ST_IO,
      ST_DONE
   } mem_state_t;

   localparam logic [15:0] DEFAULT_IO_ADDR = 16'hFFFF;

   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic ub_n;
      logic lb_n;
   } strobe_t;

   localparam strobe_t IDLE_STROBES = 5'b11111;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous board inputs
module sync_2ff #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/slc3_mem_bridge.sv
// rtl/slc3_mem_bridge.sv - req/ack bridge from the SLC-3 MAR/MDR path to async SRAM and switch/hex I/O
module slc3_mem_bridge
   import slc3_mem_pkg::*;
#(
   parameter int                    DATA_W      = 16,
   parameter int                    CPU_ADDR_W  = 16,
   parameter int                    SRAM_ADDR_W = 20,
   parameter int                    WAIT_STATES = 2,
   parameter logic [CPU_ADDR_W-1:0] IO_ADDR     = DEFAULT_IO_ADDR
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   req,
   input  logic                   we,
   input  logic [CPU_ADDR_W-1:0]  addr,
   input  logic [DATA_W-1:0]      wdata,
   output logic                   ack,
   output logic [DATA_W-1:0]      rdata,
   output logic                   busy,
   input  logic [DATA_W-1:0]      switches,
   output logic [DATA_W-1:0]      hex_reg,
   output logic                   CE_n,
   output logic                   OE_n,
   output logic                   WE_n,
   output logic                   UB_n,
   output logic                   LB_n,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0]      sram_dout,
   output logic                   sram_doe,
   input  logic [DATA_W-1:0]      sram_din
);

   if (WAIT_STATES < 1) begin : g_bad_wait_states
      $error("slc3_mem_bridge: WAIT_STATES must be at least 1");
   end

   localparam int              CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

   mem_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic [DATA_W-1:0]      hex_q, hex_d;
   logic [DATA_W-1:0]      sw_sync;
   strobe_t                strb;
   logic                   doe;
   logic                   ack_c;

   sync_2ff #(
      .WIDTH (DATA_W)
   ) u_sw_sync (
      .Clk   (Clk),
      .Reset (Reset),
      .d     (switches),
      .q     (sw_sync)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      hex_d   = hex_q;
      strb    = IDLE_STROBES;
      doe     = 1'b0;
      ack_c   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = {{(SRAM_ADDR_W-CPU_ADDR_W){1'b0}}, addr};
               wdata_d = wdata;
               if (addr == IO_ADDR) begin
                  state_d = ST_IO;
               end else if (!we) begin
                  state_d = ST_RD;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = ST_WR_SETUP;
               end
            end
         end
         ST_RD: begin
            strb.ce_n = 1'b0;
            strb.oe_n = 1'b0;
            strb.ub_n = 1'b0;
            strb.lb_n = 1'b0;
            if (cnt_q == '0) begin
               rdata_d = sram_din;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WR_SETUP: begin
            strb.ce_n = 1'b0;
            strb.ub_n = 1'b0;
            strb.lb_n = 1'b0;
            doe       = 1'b1;
            state_d   = ST_WR_PULSE;
            cnt_d     = CNT_LOAD;
         end
         ST_WR_PULSE: begin
            strb.ce_n = 1'b0;
            strb.we_n = 1'b0;
            strb.ub_n = 1'b0;
            strb.lb_n = 1'b0;
            doe       = 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_WR_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WR_HOLD: begin
            // WE_n has risen but data and address stay driven for SRAM hold time
            strb.ce_n = 1'b0;
            strb.ub_n = 1'b0;
            strb.lb_n = 1'b0;
            doe       = 1'b1;
            state_d   = ST_DONE;
         end
         ST_IO: begin
            if (we_q) begin
               hex_d = wdata_q;
            end else begin
               rdata_d = sw_sync;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            ack_c   = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         hex_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         hex_q   <= hex_d;
      end
   end

   // Strobes decode straight from state so an async reset releases them with no clock edge
   assign CE_n      = strb.ce_n;
   assign OE_n      = strb.oe_n;
   assign WE_n      = strb.we_n;
   assign UB_n      = strb.ub_n;
   assign LB_n      = strb.lb_n;
   assign sram_doe  = doe;
   assign sram_dout = wdata_q;
   assign sram_addr = addr_q;
   assign ack       = ack_c;
   assign busy      = (state_q != ST_IDLE);
   assign rdata     = rdata_q;
   assign hex_reg   = hex_q;

endmodule

// File: tb/tb_slc3_mem_bridge.sv
// tb/tb_slc3_mem_bridge.sv - directed self-checking bench for slc3_mem_bridge
module tb_slc3_mem_bridge;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic        ack;
   logic [15:0] rdata;
   logic        busy;
   logic [15:0] switches = '0;
   logic [15:0] hex_reg;
   logic        CE_n, OE_n, WE_n, UB_n, LB_n;
   logic [19:0] sram_addr;
   logic [15:0] sram_dout;
   logic        sram_doe;
   logic [15:0] sram_din;

   logic [15:0] mem [0:255];

   int n_cmp = 0;
   int n_mis = 0;

   always #5 Clk = ~Clk;

   slc3_mem_bridge #(
      .DATA_W      (16),
      .CPU_ADDR_W  (16),
      .SRAM_ADDR_W (20),
      .WAIT_STATES (2),
      .IO_ADDR     (16'hFFFF)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .ack       (ack),
      .rdata     (rdata),
      .busy      (busy),
      .switches  (switches),
      .hex_reg   (hex_reg),
      .CE_n      (CE_n),
      .OE_n      (OE_n),
      .WE_n      (WE_n),
      .UB_n      (UB_n),
      .LB_n      (LB_n),
      .sram_addr (sram_addr),
      .sram_dout (sram_dout),
      .sram_doe  (sram_doe),
      .sram_din  (sram_din)
   );

   // Async SRAM model: latch on WE_n low, drive only while selected and output-enabled
   always @(posedge Clk) begin
      if (!CE_n && !WE_n && sram_doe) mem[sram_addr[7:0]] <= sram_dout;
   end
   assign sram_din = (!CE_n && !OE_n) ? mem[sram_addr[7:0]] : 16'h0000;

   int cyc = 0;
   int overlap_cnt = 0;
   int last_doe_cyc = -1000;
   int min_gap = 1000;
   logic prev_oe_n = 1'b1;

   always @(negedge Clk) begin
      cyc = cyc + 1;
      if (sram_doe && !OE_n) overlap_cnt = overlap_cnt + 1;
      if (sram_doe) last_doe_cyc = cyc;
      if (prev_oe_n && !OE_n && (cyc - last_doe_cyc) < min_gap) min_gap = cyc - last_doe_cyc;
      prev_oe_n = OE_n;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge Clk);
      while (busy && n < 20) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 20) check("idle_timeout", 1, 0);
   endtask

   // One access; lat counts the accept cycle as 1 and ends at the ack cycle
   task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                            output int lat, output int we_lo, output int doe_hi,
                            output int oe_lo, output int ce_lo, output logic [19:0] a_seen);
      lat = 0; we_lo = 0; doe_hi = 0; oe_lo = 0; ce_lo = 0;
      wait_idle();
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge Clk);
      #1;
      req = 1'b0;
      a_seen = sram_addr;
      for (int c = 1; c <= 20; c++) begin
         if (!WE_n) we_lo++;
         if (sram_doe) doe_hi++;
         if (!OE_n) oe_lo++;
         if (!CE_n) ce_lo++;
         lat = c;
         if (ack) break;
         @(posedge Clk);
         #1;
      end
   endtask

   int lat, we_lo, doe_hi, oe_lo, ce_lo;
   logic [19:0] a_seen;
   logic [11:0] ack_mask, busy_mask;
   int acks;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

      // Reset state
      repeat (3) @(negedge Clk);
      check("rst_ce_n", CE_n, 1);
      check("rst_we_n", WE_n, 1);
      check("rst_oe_n", OE_n, 1);
      check("rst_doe", sram_doe, 0);
      check("rst_busy", busy, 0);
      check("rst_ack", ack, 0);
      check("rst_rdata", rdata, 0);
      check("rst_hex", hex_reg, 0);
      check("rst_addr", sram_addr, 0);
      Reset = 1'b0;

      // SRAM write then read of 0x0010
      do_access(1'b1, 16'h0010, 16'hBEEF, lat, we_lo, doe_hi, oe_lo, ce_lo, a_seen);
      check("wr_lat", lat, 5);
      check("wr_we_lo", we_lo, 2);
      check("wr_doe_hi", doe_hi, 4);
      check("wr_oe_lo", oe_lo, 0);
      check("wr_addr", a_seen, 20'h00010);
      do_access(1'b0, 16'h0010, 16'h0000, lat, we_lo, doe_hi, oe_lo, ce_lo, a_seen);
      check("rd_lat", lat, 3);
      check("rd_oe_lo", oe_lo, 2);
      check("rd_doe_hi", doe_hi, 0);
      check("rd_data", rdata, 16'hBEEF);
      check("rd_hex_untouched", hex_reg, 0);

      // I/O write to hex register
      do_access(1'b1, 16'hFFFF, 16'h1234, lat, we_lo, doe_hi, oe_lo, ce_lo, a_seen);
      check("io_wr_hex", hex_reg, 16'h1234);
      check("io_wr_ce_lo", ce_lo, 0);
      check("io_wr_we_lo", we_lo, 0);
      check("io_wr_lat", lat, 2);
      check("io_wr_rdata_kept", rdata, 16'hBEEF);

      // Switch read through synchroniser
      @(negedge Clk);
      switches = 16'h00A5;
      repeat (3) @(negedge Clk);
      do_access(1'b0, 16'hFFFF, 16'h0000, lat, we_lo, doe_hi, oe_lo, ce_lo, a_seen);
      check("io_rd_data", rdata, 16'h00A5);
      check("io_rd_lat", lat, 2);
      check("io_rd_ce_lo", ce_lo, 0);
      check("io_rd_hex_kept", hex_reg, 16'h1234);

      // req held for three back-to-back reads
      wait_idle();
      req = 1'b1; we = 1'b0; addr = 16'h0010;
      ack_mask = '0; busy_mask = '0; acks = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge Clk);
         #1;
         ack_mask[c]  = ack;
         busy_mask[c] = busy;
         if (ack) acks++;
         if (acks == 3) req = 1'b0;
      end
      check("b2b_ack_count", acks, 3);
      check("b2b_ack_mask", ack_mask, 12'h444);
      check("b2b_busy_mask", busy_mask, 12'h777);
      check("b2b_rdata", rdata, 16'hBEEF);
      @(posedge Clk);
      #1;
      check("b2b_no_extra", busy, 0);

      // Write immediately followed by read with req held
      wait_idle();
      req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'h5A5A;
      @(posedge Clk);
      #1;
      we = 1'b0;
      acks = 0;
      for (int c = 0; c < 30 && acks < 2; c++) begin
         if (ack) acks++;
         if (acks == 2) req = 1'b0;
         else begin
            @(posedge Clk);
            #1;
         end
      end
      req = 1'b0;
      check("wr_rd_acks", acks, 2);
      check("wr_rd_data", rdata, 16'h5A5A);

      // Async reset mid write pulse
      wait_idle();
      req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'h7777;
      @(posedge Clk);
      #1;
      req = 1'b0;
      @(posedge Clk);
      #1;
      check("pre_rst_we_n", WE_n, 0);
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst_we_n", WE_n, 1);
      check("async_rst_ce_n", CE_n, 1);
      check("async_rst_doe", sram_doe, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_hex", hex_reg, 0);
      check("async_rst_rdata", rdata, 0);
      check("async_rst_addr", sram_addr, 0);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);

      check("no_doe_oe_overlap", overlap_cnt, 0);
      check("doe_oe_gap_ok", (min_gap >= 2) ? 1 : 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/slc3_mem_bridge.md
Name: slc3_mem_bridge

Overview:
- Parametrised SRAM / memory-mapped-I/O bridge between the SLC-3 core's MAR/MDR path and the external asynchronous 1Mx16 SRAM.
- Replaces fixed-timing memory states in the control FSM with a req/ack handshake and configurable wait states.
- Decodes one I/O address: switches are read from it, and writes to it drive the hex display register.
- The tristate pad buffer stays outside this block; the block exposes separate in/out/output-enable data signals.

Parameters:
- DATA_W, 16, data bus width.
- CPU_ADDR_W, 16, CPU address width (MAR width).
- SRAM_ADDR_W, 20, SRAM address width; the CPU address is zero-extended.
- WAIT_STATES, 2, SRAM access cycles (OE low for reads, WE low for writes); minimum 1, elaboration error if 0.
- IO_ADDR, 16'hFFFF, memory-mapped switch/hex address.

Ports:
- Clk  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  CPU_ADDR_W  access address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid from the ack cycle and held until the next read completes.
- busy  out  1  high from the accept edge until the cycle after ack.
- switches  in  DATA_W  asynchronous board switches.
- hex_reg  out  DATA_W  display register.
- CE_n, OE_n, WE_n, UB_n, LB_n  out  1 each  SRAM strobes, active low.
- sram_addr  out  SRAM_ADDR_W  registered SRAM address.
- sram_dout  out  DATA_W  data driven to the pad.
- sram_doe  out  1  pad output enable.
- sram_din  in  DATA_W  data from the pad.

Behaviour:
Reset (asynchronous, immediate, including mid-access):
- State IDLE; all strobes 1; sram_doe 0; ack 0; busy 0.
- rdata 0, hex_reg 0, sram_addr 0, wait counter 0, switch synchroniser 0.

States:
- IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, IO, DONE.

Accept:
- In IDLE with req=1, the edge latches we, addr and wdata, and sets busy=1.
- Next state:
  - IO if addr == IO_ADDR.
  - Otherwise RD if we=0.
  - Otherwise WR_SETUP.
- req while busy is ignored; there is no queueing.

RD:
- CE_n = OE_n = UB_n = LB_n = 0 for exactly WAIT_STATES cycles.
- sram_din is captured into rdata on the last RD edge; then DONE.

WR_SETUP (1 cycle):
- CE_n = UB_n = LB_n = 0, WE_n = 1, sram_doe = 1, sram_dout = wdata.

WR_PULSE:
- As WR_SETUP but WE_n = 0, for WAIT_STATES cycles.

WR_HOLD (1 cycle):
- WE_n = 1; sram_doe and the address stay held.
- Then DONE.

IO (1 cycle), no SRAM strobes:
- Read: rdata is loaded with the synchronised switches.
- Write: hex_reg is loaded with wdata.
- Then DONE.

DONE (1 cycle):
- ack = 1, strobes released.
- Next state IDLE; busy drops at that edge.
- A req present in that IDLE cycle is accepted normally, giving back-to-back throughput of one access per (latency + 1) cycles.

Latency (accept edge to ack cycle):
- Read: WAIT_STATES + 1.
- Write: WAIT_STATES + 3.
- I/O: 2.

Other rules:
- sram_doe is never 1 while OE_n is 0; there is a guaranteed no-overlap cycle on read-after-write.
- switches pass through a 2-flop synchroniser before use.
- sram_addr = zero-extended addr, latched at accept and held through DONE.
- SRAM accesses never modify hex_reg; I/O accesses never toggle SRAM strobes.
- The wait counter is WAIT_STATES-sized. It loads at state entry and decrements; it never wraps.

Decomposition:
- Shared package slc3_mem_pkg:
  - State enum mem_state_t.
  - Default IO_ADDR constant.
  - Strobe-bundle struct {CE_n, OE_n, WE_n, UB_n, LB_n} with an IDLE_STROBES constant.
- One sub-module: sync_2ff (parametrised width) for the switch synchroniser.

Test Plan:
- Reset asserted mid-WR_PULSE (WE_n = 0) -> WE_n, CE_n and sram_doe return to 1/1/0 in the same cycle without a clock edge; the post-reset read of that address is not checked.
- WAIT_STATES = 2; write addr 16'h0010, data 16'hBEEF -> WE_n low exactly 2 cycles; sram_doe high 4 cycles; ack 5 cycles after accept. A following read of 16'h0010 with the SRAM model returning 16'hBEEF -> OE_n low 2 cycles, ack after 3 cycles, rdata = 16'hBEEF.
- Write 16'h1234 to 16'hFFFF -> hex_reg = 16'h1234 at the ack cycle; CE_n stays 1 throughout.
- switches = 16'h00A5 held 3 cycles, then read 16'hFFFF -> rdata = 16'h00A5, ack 2 cycles after accept.
- req held high continuously for 3 reads -> exactly 3 ack pulses, each followed by one IDLE cycle; no request is accepted while busy.
- Write immediately followed by a read -> at least one cycle with sram_doe = 0 and OE_n = 1 between them; never both active at once.
